maxima_spi_tx: RTL and testbench



---
 rtl/maxima_spi_tx.sv | 197 +++++++++++++++++++
 tb/tb_maxima_spi_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxima_spi_tx.sv
// Double-buffered, write-only SPI (mode 1) serializer for spectral-maxima frames.
// Define SPI_FRAME_HEADER_EN to prefix every frame with a sequence-counter word.
module maxima_spi_tx #(
  parameter int MAXIMAS_COUNT = 10,
  parameter int WORD_WIDTH    = 9,
  parameter int CLK_DIV       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                maximas_valid,
  input  logic [MAXIMAS_COUNT*WORD_WIDTH-1:0] maximas,
  output logic                                busy,
  output logic                                frame_done,
  output logic [7:0]                          overflow_count,
  output logic                                mosi,
  output logic                                cs,
  output logic                                sclk
);

`ifdef SPI_FRAME_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int DATA_BITS = MAXIMAS_COUNT * WORD_WIDTH;
  localparam int N         = (MAXIMAS_COUNT + HDR_WORDS) * WORD_WIDTH;
  localparam int CW        = $clog2(CLK_DIV);
  localparam int BW        = $clog2(N);

  typedef enum logic [2:0] {IDLE, START, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  fd_q, fd_d;
  logic                  busy_q, busy_d;
  logic                  pend_full_q, pend_full_d;
  logic [7:0]            ovf_q, ovf_d;
  logic [DATA_BITS-1:0]  pend_q, pend_d;
  logic [N-1:0]          sh_q, sh_d;
  logic                  div_done;
  logic                  load;
`ifdef SPI_FRAME_HEADER_EN
  logic [WORD_WIDTH-1:0] seq_q, seq_d;
`endif

  // Entry 0 lands in the top bits so a plain MSB-first shift sends it first.
  function automatic logic [N-1:0] pack_frame(input logic [DATA_BITS-1:0] pos);
    logic [N-1:0] f;
    f = '0;
    for (int k = 0; k < MAXIMAS_COUNT; k++)
      f[N-1-(k+HDR_WORDS)*WORD_WIDTH -: WORD_WIDTH] = pos[k*WORD_WIDTH +: WORD_WIDTH];
    return f;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign div_done = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    fd_d        = 1'b0;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    ovf_d       = ovf_q;
    sh_d        = sh_q;
    load        = 1'b0;
`ifdef SPI_FRAME_HEADER_EN
    seq_d       = seq_q;
`endif
    if (state_q != IDLE)
      cnt_d = div_done ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          load        = 1'b1;
          pend_full_d = 1'b0;
          sh_d        = pack_frame(pend_q);
`ifdef SPI_FRAME_HEADER_EN
          sh_d[N-1 -: WORD_WIDTH] = seq_q;
          seq_d = seq_q + 1'b1;
`endif
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (div_done) begin
          sclk_d  = 1'b1;
          mosi_d  = sh_q[N-1];
          sh_d    = {sh_q[N-2:0], 1'b0};
          bit_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          sclk_d  = 1'b0;
          state_d = (bit_q == BW'(N - 1)) ? HOLD : SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          sclk_d  = 1'b1;
          mosi_d  = sh_q[N-1];
          sh_d    = {sh_q[N-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          state_d = SHIFT_HI;
        end
      end
      HOLD: begin
        if (div_done) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          fd_d    = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load frees the pending slot in the same cycle, so a coincident strobe is kept.
    if (maximas_valid) begin
      if (!pend_full_q || load) begin
        pend_d      = maximas;
        pend_full_d = 1'b1;
      end else begin
        ovf_d = sat_inc8(ovf_q);
      end
    end

    busy_d = (state_d != IDLE) | pend_full_d;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      fd_q        <= 1'b0;
      busy_q      <= 1'b0;
      pend_full_q <= 1'b0;
      ovf_q       <= '0;
`ifdef SPI_FRAME_HEADER_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      fd_q        <= fd_d;
      busy_q      <= busy_d;
      pend_full_q <= pend_full_d;
      ovf_q       <= ovf_d;
`ifdef SPI_FRAME_HEADER_EN
      seq_q       <= seq_d;
`endif
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    sh_q   <= sh_d;
  end

  assign busy           = busy_q;
  assign frame_done     = fd_q;
  assign overflow_count = ovf_q;
  assign mosi           = mosi_q;
  assign cs             = cs_q;
  assign sclk           = sclk_q;

endmodule

// File: tb/tb_maxima_spi_tx.sv
// Bench for maxima_spi_tx: reset/cycle table, directed multi-cycle sequences,
// and random strobes checked against a frame-level reference model.
module tb_maxima_spi_tx;
  localparam int MC = 10;
  localparam int W  = 9;
  localparam int CD = 4;
`ifdef SPI_FRAME_HEADER_EN
  localparam int HW = 1;
`else
  localparam int HW = 0;
`endif
  localparam int NB     = (MC + HW) * W;
  localparam int CS_LOW = (2 * NB + 1) * CD;

  logic          clk = 1'b0;
  logic          reset;
  logic          maximas_valid;
  logic [MC*W-1:0] maximas;
  logic          busy, frame_done, mosi, cs, sclk;
  logic [7:0]    overflow_count;

  maxima_spi_tx #(.MAXIMAS_COUNT(MC), .WORD_WIDTH(W), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .maximas_valid(maximas_valid), .maximas(maximas),
    .busy(busy), .frame_done(frame_done), .overflow_count(overflow_count),
    .mosi(mosi), .cs(cs), .sclk(sclk)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: transmitter busy for a fixed time per frame, one pending slot.
  typedef struct { logic [MC*W-1:0] data; logic [W-1:0] seq; } frame_t;
  frame_t          exp_q[$];
  int              m_left = 0;
  bit              m_pend_full = 0;
  logic [MC*W-1:0] m_pend;
  int              m_ovf = 0;
  logic [W-1:0]    m_seq = '0;

  bit mon_en = 0;
  bit track_busy = 0;
  int busy_err = 0, ovf_err = 0, busy_low = 0;
  int idle_mosi_err = 0, stray_done = 0, frames_done = 0, aborts = 0, last_gap = -1;

  task automatic model_step();
    frame_t f;
    if (reset) begin
      m_left = 0; m_pend_full = 0; m_ovf = 0; m_seq = '0;
      exp_q.delete();
      return;
    end
    if (m_left == 0 && m_pend_full) begin
      f.data = m_pend; f.seq = m_seq;
      exp_q.push_back(f);
      m_seq = m_seq + 1'b1;
      m_left = (2 * NB + 2) * CD;
      m_pend_full = 0;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (maximas_valid) begin
      if (!m_pend_full) begin
        m_pend = maximas; m_pend_full = 1;
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (mon_en) begin
      if (busy !== ((m_left > 0) || m_pend_full)) busy_err++;
      if (overflow_count !== 8'(m_ovf)) ovf_err++;
      if (track_busy && !busy) busy_low++;
    end
  endtask

  task automatic idle_cycles(input int n);
    maximas_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [MC*W-1:0] d);
    maximas = d; maximas_valid = 1'b1;
    tick();
    maximas_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    maximas_valid = 1'b0;
    while ((busy || !cs) && n < limit) begin
      tick(); n++;
    end
    check("idle_reached", (n < limit), 1);
  endtask

  function automatic logic [MC*W-1:0] ramp_frame(input int mul, input int add);
    logic [MC*W-1:0] d;
    for (int k = 0; k < MC; k++) d[k*W +: W] = W'(mul * k + add);
    return d;
  endfunction

  function automatic logic [MC*W-1:0] rand_frame();
    logic [MC*W-1:0] d;
    for (int k = 0; k < MC; k++) d[k*W +: W] = W'($urandom);
    return d;
  endfunction

  // Serial-link monitor: decodes words from bits sampled on sclk falling edges.
  bit rx_bits[$];

  function automatic int first_bad(input frame_t f, output logic [W-1:0] got,
                                   output logic [W-1:0] want);
    got = '0; want = '0;
    for (int j = 0; j < MC + HW; j++) begin
      got = '0;
      for (int b = 0; b < W; b++) got = {got[W-2:0], rx_bits[j*W+b]};
      if (j < HW) want = f.seq;
      else        want = f.data[(j-HW)*W +: W];
      if (got !== want) return j;
    end
    return -1;
  endfunction

  initial begin
    bit pcs, psclk, abort;
    int cyc, fall_t, rise_t, bad;
    frame_t f;
    logic [W-1:0] g, wv;
    pcs = 1; psclk = 0; abort = 0; cyc = 0; fall_t = 0; rise_t = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) abort = 1;
      if (mon_en) begin
        if (cs && mosi !== 1'b0) idle_mosi_err++;
        if (pcs && !cs) begin
          fall_t = cyc;
          rx_bits.delete();
          if (rise_t >= 0) last_gap = cyc - rise_t;
          abort = 0;
        end
        if (!cs && psclk && !sclk) rx_bits.push_back(mosi);
        if (!pcs && cs) begin
          rise_t = cyc;
          if (abort) begin
            check("abort_no_frame_done", frame_done, 0);
            aborts++;
          end else begin
            check("frame_done_at_cs_rise", frame_done, 1);
            check("cs_low_cycles", cyc - fall_t, CS_LOW);
            check("bit_count", rx_bits.size(), NB);
            if (exp_q.size() == 0) begin
              check("frame_expected", 0, 1);
            end else begin
              f = exp_q.pop_front();
              frames_done++;
              tests++;
              bad = (rx_bits.size() == NB) ? first_bad(f, g, wv) : -2;
              if (bad != -1) begin
                fails++;
                $display("FAIL frame_word[%0d]: got %0d, expected %0d", bad, g, wv);
              end
            end
          end
        end else if (frame_done) begin
          stray_done++;
        end
      end
      pcs = cs; psclk = sclk;
    end
  end

  typedef struct { bit rst; bit vld; bit cs; bit sclk; bit mosi; bit busy; bit fd; } vec_t;
  vec_t tbl[15];

  initial begin
    bit fb;
    int fb0;
    reset = 1'b1; maximas_valid = 1'b0; maximas = '0;
    for (int i = 0; i < 20; i++) begin
      tick(); mon_en = 1;
    end
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow_count, 0);

    // Cycle table: entry0=0x1FF; first two bits are 1 (or header seq 0 bits).
    fb = (HW == 0);
    tbl[0] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 1, 0};
    for (int i = 2; i <= 5; i++)   tbl[i] = '{0, 0, 0, 0, 0, 1, 0};
    for (int i = 6; i <= 9; i++)   tbl[i] = '{0, 0, 0, 1, fb, 1, 0};
    for (int i = 10; i <= 13; i++) tbl[i] = '{0, 0, 0, 0, fb, 1, 0};
    tbl[14] = '{0, 0, 0, 1, fb, 1, 0};
    maximas = '0;
    maximas[W-1:0] = '1;
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; maximas_valid = tbl[i].vld;
      tick();
      check($sformatf("vec%0d{cs,sclk,mosi,busy,fd}", i),
            {cs, sclk, mosi, busy, frame_done},
            {tbl[i].cs, tbl[i].sclk, tbl[i].mosi, tbl[i].busy, tbl[i].fd});
    end
    reset = 1'b0; maximas_valid = 1'b0;
    wait_idle(2000);
    check("frames_after_table", frames_done, 1);

    // Entry k = 3k+1, latency capture -> load.
    fb0 = frames_done;
    strobe(ramp_frame(3, 1));
    check("lat_cs_high_after_capture", cs, 1);
    tick();
    check("lat_cs_low_after_load", cs, 0);
    wait_idle(2000);
    check("frames_ramp", frames_done - fb0, 1);

    // Two strobes 100 cycles apart: back-to-back frames.
    fb0 = frames_done; busy_low = 0; track_busy = 1;
    strobe(ramp_frame(5, 2));
    idle_cycles(99);
    strobe(ramp_frame(7, 100));
    for (int n = 0; n < 3000 && frames_done < fb0 + 2; n++) tick();
    track_busy = 0;
    check("b2b_frames", frames_done - fb0, 2);
    check("b2b_gap", last_gap, CD + 1);
    check("b2b_busy_low_cycles", busy_low, 0);
    check("b2b_overflow", overflow_count, 0);
    wait_idle(2000);

    // Three strobes 50 apart during one frame: third dropped.
    fb0 = frames_done;
    strobe(ramp_frame(1, 10));
    idle_cycles(49);
    strobe(ramp_frame(2, 20));
    idle_cycles(49);
    strobe(ramp_frame(4, 30));
    wait_idle(4000);
    check("drop_frames", frames_done - fb0, 2);
    check("drop_overflow", overflow_count, 1);

    // Reset 300 cycles into a frame aborts it.
    strobe(rand_frame());
    for (int n = 0; n < 10 && cs; n++) tick();
    check("abort_cs_went_low", cs, 0);
    idle_cycles(300);
    reset = 1'b1;
    tick();
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_fd", frame_done, 0);
    check("abort_overflow_cleared", overflow_count, 0);
    reset = 1'b0;
    fb0 = frames_done;
    strobe(ramp_frame(11, 3));
    wait_idle(2000);
    check("abort_seen", aborts, 1);
    check("after_abort_frames", frames_done - fb0, 1);

    // Strobe every cycle: overflow saturates at 255.
    fb0 = frames_done;
    maximas_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      maximas = rand_frame();
      tick();
    end
    maximas_valid = 1'b0;
    check("sat_overflow", overflow_count, 255);
    wait_idle(4000);
    check("sat_frames", frames_done - fb0, 2);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Random strobes against the model.
    for (int i = 0; i < 8000; i++) begin
      maximas_valid = ($urandom_range(299) == 0);
      if (maximas_valid) maximas = rand_frame();
      tick();
    end
    wait_idle(5000);
    check("rand_overflow_vs_model", overflow_count, m_ovf);
    check("rand_all_frames_sent", exp_q.size(), 0);

    check("busy_vs_model_errors", busy_err, 0);
    check("overflow_vs_model_errors", ovf_err, 0);
    check("mosi_nonzero_with_cs_high", idle_mosi_err, 0);
    check("stray_frame_done", stray_done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
